// File: rtl/mpu6050_i2c_responder.sv
// I2C target emulating the MPU6050 register subset: config writes and burst reads of sampled sensor data.
// Optional MPU_RESP_SLEEP_GATE_EN: SLEEP (0x6B[6]) blanks data reads and suppresses snapshots.
//
// state   | meaning
// IDLE    | bus free, waiting for START
// DEV     | shifting in address + R/W
// DEV_ACK | acking our address
// REG     | shifting in register pointer
// REG_ACK | acking pointer byte
// WR      | shifting in write data
// WR_ACK  | acking write data (write committed on entry)
// RD      | driving read data bits
// RD_ACK  | sampling master ACK/NACK
// IGNORE  | not addressed or read ended, wait for START/STOP
module mpu6050_i2c_responder #(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         scl_in,
  input  logic         sda_in,
  output logic         sda_oe_out,
  input  logic [111:0] sensor_data_in,
  output logic         snapshot_out,
  output logic [7:0]   smplrt_div_out,
  output logic [7:0]   config_out,
  output logic [7:0]   gyro_cfg_out,
  output logic [7:0]   accel_cfg_out,
  output logic [7:0]   pwr_mgmt_out
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   scl_sync, sda_sync;
  logic         scl_prev, sda_prev;
  logic         scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]   cnt_q, cnt_d;
  logic [7:0]   shift_q, shift_d, ptr_q, ptr_d, rd_byte_q, rd_byte_d, ptr_inc;
  logic         rw_q, rw_d, sda_oe_q, sda_oe_d, snapshot_q, snapshot_d;
  logic         sleep_gate, collect;
  logic [111:0] shadow_q, shadow_d;
  logic [7:0]   smplrt_q, smplrt_d, config_q, config_d, gyro_q, gyro_d;
  logic [7:0]   accel_q, accel_d, pwr_q, pwr_d;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
  assign ptr_inc   = ptr_q + 8'd1;
  assign collect   = (state_q == DEV || state_q == REG || state_q == WR) && scl_rise && (cnt_q < 4'd8);

`ifdef MPU_RESP_SLEEP_GATE_EN
  assign sleep_gate = pwr_q[6];
`else
  assign sleep_gate = 1'b0;
`endif

  function automatic logic [7:0] read_map(input logic [7:0] addr, input logic [111:0] data,
                                          input logic gate);
    logic [3:0] idx;
    logic [6:0] msb;
    idx = 4'(addr - 8'h3B);
    msb = 7'd111 - {idx, 3'b000};
    read_map = 8'h00;
    if (addr >= 8'h3B && addr <= 8'h48) begin
      read_map = gate ? 8'h00 : data[msb -: 8];
    end else begin
      case (addr)
        8'h19:   read_map = smplrt_q;
        8'h1A:   read_map = config_q;
        8'h1B:   read_map = gyro_q;
        8'h1C:   read_map = accel_q;
        8'h6B:   read_map = pwr_q;
        8'h75:   read_map = WHO_AM_I_VAL;
        default: read_map = 8'h00;
      endcase
    end
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scl_sync   <= 2'b11;
      sda_sync   <= 2'b11;
      scl_prev   <= 1'b1;
      sda_prev   <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      rd_byte_q  <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      snapshot_q <= 1'b0;
      shadow_q   <= '0;
      smplrt_q   <= 8'h00;
      config_q   <= 8'h00;
      gyro_q     <= 8'h00;
      accel_q    <= 8'h00;
      pwr_q      <= 8'h40;
    end else begin
      scl_sync   <= {scl_sync[0], scl_in};
      sda_sync   <= {sda_sync[0], sda_in};
      scl_prev   <= scl_s;
      sda_prev   <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rd_byte_q  <= rd_byte_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      snapshot_q <= snapshot_d;
      shadow_q   <= shadow_d;
      smplrt_q   <= smplrt_d;
      config_q   <= config_d;
      gyro_q     <= gyro_d;
      accel_q    <= accel_d;
      pwr_q      <= pwr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rd_byte_d  = rd_byte_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    snapshot_d = 1'b0;
    shadow_d   = shadow_q;
    smplrt_d   = smplrt_q;
    config_d   = config_q;
    gyro_d     = gyro_q;
    accel_d    = accel_q;
    pwr_d      = pwr_q;
    // bus conditions take priority over any SCL edge seen in the same cycle
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else if (start_det) begin
      state_d  = DEV;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      if (collect) begin
        shift_d = {shift_q[6:0], sda_s};
        cnt_d   = cnt_q + 4'd1;
      end
      case (state_q)
        DEV: if (scl_fall && cnt_q == 4'd8) begin
          cnt_d = 4'd0;
          if (shift_q[7:1] == DEV_ADDR) begin
            sda_oe_d = 1'b1;
            rw_d     = shift_q[0];
            state_d  = DEV_ACK;
            if (shift_q[0]) begin
              // first byte comes straight from the bus since the shadow loads this same cycle
              rd_byte_d = read_map(ptr_q, sensor_data_in, sleep_gate);
              if (!sleep_gate) begin
                shadow_d   = sensor_data_in;
                snapshot_d = 1'b1;
              end
            end
          end else begin
            state_d = IGNORE;
          end
        end
        DEV_ACK: if (scl_fall) begin
          if (rw_q) begin
            state_d  = RD;
            sda_oe_d = ~rd_byte_q[7];
            cnt_d    = 4'd1;
          end else begin
            state_d  = REG;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
          end
        end
        REG: if (scl_fall && cnt_q == 4'd8) begin
          ptr_d    = shift_q;
          sda_oe_d = 1'b1;
          cnt_d    = 4'd0;
          state_d  = REG_ACK;
        end
        REG_ACK, WR_ACK: if (scl_fall) begin
          sda_oe_d = 1'b0;
          cnt_d    = 4'd0;
          state_d  = WR;
        end
        WR: if (scl_fall && cnt_q == 4'd8) begin
          case (ptr_q)
            8'h19:   smplrt_d = shift_q;
            8'h1A:   config_d = shift_q;
            8'h1B:   gyro_d   = shift_q;
            8'h1C:   accel_d  = shift_q;
            8'h6B:   pwr_d    = shift_q;
            default: ;
          endcase
          ptr_d    = ptr_inc;
          sda_oe_d = 1'b1;
          cnt_d    = 4'd0;
          state_d  = WR_ACK;
        end
        RD: if (scl_fall) begin
          if (cnt_q < 4'd8) begin
            sda_oe_d = ~rd_byte_q[3'd7 - cnt_q[2:0]];
            cnt_d    = cnt_q + 4'd1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IGNORE;
            end else begin
              ptr_d     = ptr_inc;
              rd_byte_d = read_map(ptr_inc, shadow_q, sleep_gate);
              cnt_d     = 4'd9;
            end
          end else if (scl_fall && cnt_q == 4'd9) begin
            state_d  = RD;
            sda_oe_d = ~rd_byte_q[7];
            cnt_d    = 4'd1;
          end
        end
        IDLE, IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe_out     = sda_oe_q;
  assign snapshot_out   = snapshot_q;
  assign smplrt_div_out = smplrt_q;
  assign config_out     = config_q;
  assign gyro_cfg_out   = gyro_q;
  assign accel_cfg_out  = accel_q;
  assign pwr_mgmt_out   = pwr_q;

endmodule
